// File: rtl/seq_nonrestoring_divider.sv
// seq_nonrestoring_divider: multi-cycle non-restoring divider retiring one quotient bit per clock.
// Define SEQ_DIV_SIGNED_EN to add the signed_op port and truncating two's complement division.
module seq_nonrestoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   a_sh, a_new;
    logic [WIDTH-1:0] r_mag;

    // In signed mode the core only ever sees magnitudes; signs are reapplied on completion.
    always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
        dvd_neg = signed_op & dividend[WIDTH-1];
        dvs_neg = signed_op & divisor[WIDTH-1];
`else
        dvd_neg = 1'b0;
        dvs_neg = 1'b0;
`endif
        dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
        dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        dvd_d   = dvd_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        a_sh    = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
        a_new   = a_q[WIDTH] ? (a_sh + m_q) : (a_sh - m_q);
        r_mag   = a_q[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = dvd_mag;
                    m_d     = {1'b0, dvs_mag};
                    cnt_d   = CNT_W'(WIDTH);
                    dz_d    = (divisor == '0);
                    dvd_d   = dividend;
                    q_neg_d = dvd_neg ^ dvs_neg;
                    r_neg_d = dvd_neg;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_new;
                q_d   = {q_q[WIDTH-2:0], ~a_new[WIDTH]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // A negative partial remainder is one divisor short of the true remainder.
                if (a_q[WIDTH]) begin
                    a_d = a_q + m_q;
                end
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (dz_q) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                end else begin
                    quo_d = q_neg_q ? (~q_q + 1'b1) : q_q;
                    rem_d = r_neg_q ? (~r_mag + 1'b1) : r_mag;
                end
                dbz_d   = dz_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            dvd_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            dvd_q   <= dvd_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
